// File: rtl/rr_pkg.sv
// Shared definitions for round-robin arbitration blocks.
//   state_e  : output-slot occupancy (EMPTY / FULL)
//   next_idx : successor of a requester index, wrapping at 2**control_w
package rr_pkg;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_e;

  // (idx + 1) mod 2**control_w; the wrap from the last index yields 0.
  function automatic int unsigned next_idx(input int unsigned idx,
                                           input int unsigned control_w);
    return (idx + 32'd1) % (32'd1 << control_w);
  endfunction

endpackage

// File: rtl/rr_mux_arbiter_pick.sv
// Combinational round-robin picker.
//   req_i       : request vector, one bit per requester
//   ptr_i       : index with highest priority this cycle
//   gnt_valid_o : at least one request is set
//   gnt_idx_o   : first set index searching upward from ptr_i, wrapping
module rr_pick #(
  parameter int CONTROL = 2
) (
  input  logic [(2**CONTROL)-1:0] req_i,
  input  logic [CONTROL-1:0]      ptr_i,
  output logic                    gnt_valid_o,
  output logic [CONTROL-1:0]      gnt_idx_o
);

  localparam int N = 2**CONTROL;

  logic [N-1:0]       rot;
  logic [CONTROL-1:0] off;

  // Rotate so that ptr_i lands on bit 0; a plain lowest-bit priority
  // encoder then implements the wrapped search, and adding ptr_i back
  // (modulo N through the CONTROL-bit width) undoes the rotation.
  always_comb begin
    rot         = '0;
    off         = '0;
    gnt_valid_o = 1'b0;
    for (int k = 0; k < N; k++) begin
      rot[k] = req_i[CONTROL'(k) + ptr_i];
    end
    for (int k = N - 1; k >= 0; k--) begin
      if (rot[k]) begin
        gnt_valid_o = 1'b1;
        off         = CONTROL'(k);
      end
    end
    gnt_idx_o = off + ptr_i;
  end

endmodule

// File: rtl/rr_mux_arbiter.sv
// N-to-1 round-robin merge stage with a single registered output slot.
//   clk, rst_n : system clock (rising edge), asynchronous active-low reset
//   in_valid   : per-requester beat pending
//   in_data    : per-requester payload (unpacked array, index = requester)
//   in_ready   : one-hot (or zero) acceptance of the granted requester
//   out_valid  : output slot holds a beat
//   out_data   : registered payload of the held beat
//   out_sel    : requester index that produced out_data (drives return demux)
//   out_ready  : downstream consumes the held beat this cycle
module rr_mux_arbiter
  import rr_pkg::*;
#(
  parameter int CONTROL    = 2,
  parameter int DATA_WIDTH = 32
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [(2**CONTROL)-1:0]      in_valid,
  input  logic [DATA_WIDTH-1:0]        in_data [2**CONTROL],
  output logic [(2**CONTROL)-1:0]      in_ready,
  output logic                         out_valid,
  output logic [DATA_WIDTH-1:0]        out_data,
  output logic [CONTROL-1:0]           out_sel,
  input  logic                         out_ready
);

  state_e                  state_q, state_d;
  logic [CONTROL-1:0]      ptr_q, ptr_d;
  logic [CONTROL-1:0]      sel_q, sel_d;
  logic [DATA_WIDTH-1:0]   data_q, data_d;

  logic                    gnt_valid;
  logic [CONTROL-1:0]      gnt_idx;
  logic                    load_en;
  logic                    accept;

  rr_pick #(
    .CONTROL(CONTROL)
  ) u_pick (
    .req_i      (in_valid),
    .ptr_i      (ptr_q),
    .gnt_valid_o(gnt_valid),
    .gnt_idx_o  (gnt_idx)
  );

  // The slot can take a new beat when it is empty or being drained now.
  // rst_n is folded in so no requester sees ready while reset is held.
  assign load_en = (state_q == EMPTY) | out_ready;
  assign accept  = rst_n & load_en & gnt_valid;

  always_comb begin
    in_ready = '0;
    if (accept) begin
      in_ready[gnt_idx] = 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    sel_d   = sel_q;
    data_d  = data_q;
    if (accept) begin
      // Covers both a load into an empty slot and drain-and-replace.
      state_d = FULL;
      data_d  = in_data[gnt_idx];
      sel_d   = gnt_idx;
      ptr_d   = CONTROL'(next_idx(32'(gnt_idx), CONTROL));
    end else if (out_ready) begin
      // Payload is left as-is; it is a don't-care once the slot is empty.
      state_d = EMPTY;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= EMPTY;
      ptr_q   <= '0;
      sel_q   <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      sel_q   <= sel_d;
      data_q  <= data_d;
    end
  end

  assign out_valid = (state_q == FULL);
  assign out_data  = data_q;
  assign out_sel   = sel_q;

endmodule

// File: tb/tb_rr_mux_arbiter.sv
module tb_rr_mux_arbiter;

  localparam int CONTROL    = 2;
  localparam int DATA_WIDTH = 32;
  localparam int N          = 4;

  typedef struct {
    logic [CONTROL-1:0]    sel;
    logic [DATA_WIDTH-1:0] data;
  } beat_t;

  logic                  clk;
  logic                  rst_n;
  logic [N-1:0]          in_valid;
  logic [DATA_WIDTH-1:0] in_data [N];
  logic [N-1:0]          in_ready;
  logic                  out_valid;
  logic [DATA_WIDTH-1:0] out_data;
  logic [CONTROL-1:0]    out_sel;
  logic                  out_ready;

  int    n_checks;
  int    n_fails;
  beat_t sb[$];
  int    m_ptr;
  bit    m_full;

  rr_mux_arbiter #(
    .CONTROL   (CONTROL),
    .DATA_WIDTH(DATA_WIDTH)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_data  (in_data),
    .in_ready (in_ready),
    .out_valid(out_valid),
    .out_data (out_data),
    .out_sel  (out_sel),
    .out_ready(out_ready)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One cycle: compare combinational and registered outputs against the
  // reference model, update the model and scoreboard, then cross the edge.
  task automatic step(input string tag);
    logic [N-1:0] exp_rdy;
    bit           found;
    int           g;
    beat_t        b;
    #2;
    found   = 1'b0;
    g       = 0;
    exp_rdy = '0;
    for (int k = 0; k < N; k++) begin
      if (!found && in_valid[(m_ptr + k) % N]) begin
        found = 1'b1;
        g     = (m_ptr + k) % N;
      end
    end
    if (found && (!m_full || out_ready)) exp_rdy[g] = 1'b1;
    check({tag, ".in_ready"}, 64'(in_ready), 64'(exp_rdy));
    check({tag, ".out_valid"}, 64'(out_valid), 64'(m_full));
    if (m_full) begin
      if (sb.size() == 0) begin
        check({tag, ".sb_empty"}, 64'(sb.size()), 64'd1);
      end else begin
        b = sb[0];
        check({tag, ".out_sel"}, 64'(out_sel), 64'(b.sel));
        check({tag, ".out_data"}, 64'(out_data), 64'(b.data));
        if (out_ready) void'(sb.pop_front());
      end
    end
    if (found && (!m_full || out_ready)) begin
      b.sel  = CONTROL'(g);
      b.data = in_data[g];
      sb.push_back(b);
      m_ptr  = (g + 1) % N;
      m_full = 1'b1;
    end else if (out_ready) begin
      m_full = 1'b0;
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_checks  = 0;
    n_fails   = 0;
    m_ptr     = 0;
    m_full    = 1'b0;
    rst_n     = 1'b0;
    in_valid  = '0;
    out_ready = 1'b0;
    for (int i = 0; i < N; i++) in_data[i] = '0;

    // Power-on reset, requests present but must not be acknowledged
    in_valid = 4'b1111;
    out_ready = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1;
    check("por.out_valid", 64'(out_valid), 64'd0);
    check("por.out_sel", 64'(out_sel), 64'd0);
    check("por.out_data", 64'(out_data), 64'd0);
    check("por.in_ready", 64'(in_ready), 64'd0);
    in_valid = '0;
    rst_n    = 1'b1;

    // Fairness: all requesting, one beat per cycle, sel 0,1,2,3,0
    for (int i = 0; i < N; i++) in_data[i] = 32'hA0 + 32'(i);
    in_valid  = 4'b1111;
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) step("rr");
    in_valid = '0;
    step("rr_drain");

    // Single source (ptr now 1): grant 2, ptr becomes 3
    in_valid   = 4'b0100;
    in_data[2] = 32'h1234;
    step("single");
    in_valid = '0;
    step("single_out");

    // Wrap: ptr=3 with requesters 3 and 0 -> 3 first, then 0, ptr -> 1
    in_data[0] = 32'hB0;
    in_data[3] = 32'hB3;
    in_valid   = 4'b1001;
    step("wrap3");
    in_valid = 4'b0001;
    step("wrap0");
    in_valid = '0;
    step("wrap_out");

    // ptr=1 picks requester 1 over 0; then drain and reload in one cycle
    in_data[0] = 32'hC0;
    in_data[1] = 32'hC1;
    in_valid   = 4'b0011;
    step("ptr1");
    in_valid = 4'b0001;
    step("drain_load");
    in_valid = '0;
    step("drain_load_out");

    // Backpressure: hold sel=1/0x55 for three stalled cycles
    in_data[1] = 32'h55;
    in_data[2] = 32'h66;
    in_valid   = 4'b0010;
    step("bp_load");
    in_valid  = 4'b0110;
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) step("bp_stall");
    out_ready = 1'b1;
    in_valid  = 4'b0100;
    step("bp_release");
    in_valid = '0;
    step("bp_out");

    // Randomized traffic against the model
    for (int i = 0; i < 40; i++) begin
      in_valid = N'($urandom_range(0, 15));
      for (int j = 0; j < N; j++) in_data[j] = $urandom;
      out_ready = 1'($urandom_range(0, 1));
      step("rand");
    end
    in_valid  = '0;
    out_ready = 1'b1;
    step("rand_drain");
    step("rand_idle");

    // Asynchronous reset while FULL holding 0xDEAD
    in_data[1] = 32'hDEAD;
    in_valid   = 4'b0010;
    step("dead_load");
    in_valid  = '0;
    out_ready = 1'b0;
    step("dead_hold");
    in_valid  = 4'b1111;
    out_ready = 1'b1;
    #2;
    rst_n = 1'b0;
    #1;
    check("arst.out_valid", 64'(out_valid), 64'd0);
    check("arst.out_sel", 64'(out_sel), 64'd0);
    check("arst.out_data", 64'(out_data), 64'd0);
    check("arst.in_ready", 64'(in_ready), 64'd0);
    sb.delete();
    m_ptr  = 0;
    m_full = 1'b0;
    @(posedge clk);
    #1;
    check("arst_hold.in_ready", 64'(in_ready), 64'd0);
    rst_n = 1'b1;
    for (int i = 0; i < N; i++) in_data[i] = 32'hE0 + 32'(i);
    step("post_rst");
    in_valid = '0;
    step("post_rst_out");
    step("post_rst_idle");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
